// File: rtl/window_line_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a column-shift window,
// and taps falling outside the image are zeroed or clamped to the nearest edge pixel.
module window_line_buffer #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int PIX_W       = 12,
    parameter int BORDER_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [PIX_W-1:0]         inPixel,
    input  logic                     inSof,
    output logic                     outValid,
    output logic [$clog2(IMG_W)-1:0] outX,
    output logic [$clog2(IMG_H)-1:0] outY,
    output logic [9*PIX_W-1:0]       winOut,
    output logic                     outEof
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t r_state, w_state_next;

    logic [PIX_W-1:0] r_lb0 [IMG_W];   // row y-1 relative to the incoming pixel
    logic [PIX_W-1:0] r_lb1 [IMG_W];   // row y-2
    logic [PIX_W-1:0] r_rd0, r_rd1;
    logic [PIX_W-1:0] r_raw [9];
    logic [PIX_W-1:0] w_raw_next [9];
    logic [PIX_W-1:0] w_vec [3];
    logic [9*PIX_W-1:0] w_win;
    logic [XW-1:0] r_col, w_col_next, w_wr_col;
    logic [YW-1:0] r_row;
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic w_accept, w_sof_take, w_pix_take, w_shift, w_emit, w_last_in, w_last_ctr;

    assign inReady    = (r_state != FLUSH);
    assign w_accept   = inValid && inReady;
    assign w_sof_take = w_accept && inSof;
    assign w_pix_take = w_accept && !inSof && (r_state == RUN);
    assign w_shift    = w_pix_take || w_sof_take || (r_state == FLUSH);
    assign w_last_in  = (r_row == Y_LAST) && (r_col == X_LAST);
    assign w_last_ctr = (r_cy == Y_LAST) && (r_cx == X_LAST);
    assign w_emit     = (w_pix_take && ((r_row > YW'(1)) || (r_row == YW'(1) && r_col != '0)))
                        || (r_state == FLUSH);
    assign w_wr_col   = w_sof_take ? '0 : r_col;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        case (r_state)
            IDLE:    if (w_sof_take) w_state_next = RUN;
            RUN:     if (!w_sof_take && w_pix_take && w_last_in) w_state_next = FLUSH;
            FLUSH:   if (w_last_ctr) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_sof_take) begin
            w_col_next = XW'(1);
        end else if (w_shift) begin
            w_col_next = (r_col == X_LAST) ? '0 : r_col + 1'b1;
        end
        if (r_state == FLUSH && w_last_ctr) begin
            w_col_next = '0;
        end
    end

    // Read address is always the column of the next pixel, so the line-buffer
    // taps are already registered when that pixel arrives.
    always_ff @(posedge clk) begin
        if (w_pix_take || w_sof_take) begin
            r_lb0[w_wr_col] <= inPixel;
            r_lb1[w_wr_col] <= r_rd0;
        end
        r_rd0 <= r_lb0[w_col_next];
        r_rd1 <= r_lb1[w_col_next];
    end

    assign w_vec[0] = r_rd1;
    assign w_vec[1] = r_rd0;
    assign w_vec[2] = (r_state == FLUSH) ? '0 : inPixel;

    genvar gi;
    for (gi = 0; gi < 9; gi++) begin : g_shift
        if (gi % 3 == 2) begin : g_new
            assign w_raw_next[gi] = w_vec[gi / 3];
        end else begin : g_old
            assign w_raw_next[gi] = r_raw[gi + 1];
        end
    end

    for (gi = 0; gi < 9; gi++) begin : g_tap
        localparam int R = gi / 3;
        localparam int C = gi % 3;
        logic w_row_out, w_col_out;
        assign w_col_out = (C == 0 && r_cx == '0) || (C == 2 && r_cx == X_LAST);
        assign w_row_out = (R == 0 && r_cy == '0) || (R == 2 && r_cy == Y_LAST);
        if (BORDER_MODE == 0) begin : g_zero
            assign w_win[gi*PIX_W +: PIX_W] = (w_row_out || w_col_out) ? '0 : w_raw_next[gi];
        end else begin : g_clamp
            logic [3:0] w_idx;
            assign w_idx = 4'((w_row_out ? 3 : 3 * R) + (w_col_out ? 1 : C));
            assign w_win[gi*PIX_W +: PIX_W] = w_raw_next[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_col    <= '0;
            r_row    <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            for (int i = 0; i < 9; i++) r_raw[i] <= '0;
            outValid <= 1'b0;
            outEof   <= 1'b0;
            outX     <= '0;
            outY     <= '0;
            winOut   <= '0;
        end else begin
            outValid <= w_emit;
            outEof   <= w_emit && w_last_ctr;
            r_col    <= w_col_next;
            if (w_sof_take) begin
                r_row <= '0;
            end else if (w_pix_take && r_col == X_LAST) begin
                r_row <= (r_row == Y_LAST) ? '0 : r_row + 1'b1;
            end
            if (w_shift) begin
                for (int i = 0; i < 9; i++) r_raw[i] <= w_raw_next[i];
            end
            if (w_sof_take) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (w_emit) begin
                outX   <= r_cx;
                outY   <= r_cy;
                winOut <= w_win;
                r_cx   <= (r_cx == X_LAST) ? '0 : r_cx + 1'b1;
                if (r_cx == X_LAST) begin
                    r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_line_buffer.sv
// Two instances (zero-fill and edge-replicate borders) driven in parallel and compared
// every cycle against a frame-array reference model of the window stream.
`timescale 1ns/1ps
module tb_window_line_buffer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 12;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic inValid = 1'b0;
    logic inSof = 1'b0;
    logic [PW-1:0] inPixel = '0;
    logic rdy0, rdy1, val0, val1, eof0, eof1;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [9*PW-1:0] win0, win1;

    always #5 clk = ~clk;

    window_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BORDER_MODE(0)) u_dut0 (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(rdy0), .inPixel(inPixel),
        .inSof(inSof), .outValid(val0), .outX(x0), .outY(y0), .winOut(win0), .outEof(eof0));

    window_line_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BORDER_MODE(1)) u_dut1 (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(rdy1), .inPixel(inPixel),
        .inSof(inSof), .outValid(val1), .outX(x1), .outY(y1), .winOut(win1), .outEof(eof1));

    int n_pass = 0;
    int n_total = 0;
    int win_cnt = 0;
    int n_busy = 0;

    // Reference model: current frame as a flat array plus linear-index bookkeeping.
    int img [N];
    bit m_run = 1'b0;
    int m_n = 0;
    int m_flush = 0;
    logic m_v = 1'b0;
    logic m_eof = 1'b0;
    logic [XW-1:0] m_x = '0;
    logic [YW-1:0] m_y = '0;
    logic [9*PW-1:0] m_w0 = '0;
    logic [9*PW-1:0] m_w1 = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [9*PW-1:0] ref_win(input int c, input int mode);
        logic [9*PW-1:0] w;
        int cx, cy, nx, ny;
        w  = '0;
        cx = c % W;
        cy = c / W;
        for (int k = 0; k < 9; k++) begin
            nx = cx + k % 3 - 1;
            ny = cy + k / 3 - 1;
            if (mode == 1) begin
                if (nx < 0) nx = 0;
                if (nx > W - 1) nx = W - 1;
                if (ny < 0) ny = 0;
                if (ny > H - 1) ny = H - 1;
                w[k*PW +: PW] = PW'(img[ny*W + nx]);
            end else if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
                w[k*PW +: PW] = PW'(img[ny*W + nx]);
            end
        end
        return w;
    endfunction

    task automatic model_edge();
        bit acc;
        int c;
        m_v   = 1'b0;
        m_eof = 1'b0;
        c     = -1;
        acc   = inValid && (m_flush == 0);
        if (m_flush > 0) begin
            c = N - m_flush;
            m_flush--;
        end else if (acc && inSof) begin
            img[0] = int'(inPixel);
            m_n    = 1;
            m_run  = 1'b1;
        end else if (acc && m_run) begin
            img[m_n] = int'(inPixel);
            if (m_n >= W + 1) c = m_n - W - 1;
            if (m_n == N - 1) begin
                m_run   = 1'b0;
                m_flush = W + 1;
            end
            m_n++;
        end
        if (c >= 0) begin
            m_v   = 1'b1;
            m_eof = (c == N - 1);
            m_x   = XW'(c % W);
            m_y   = YW'(c / W);
            m_w0  = ref_win(c, 0);
            m_w1  = ref_win(c, 1);
        end
    endtask

    task automatic cycle(input logic v, input logic sof, input logic [PW-1:0] pix);
        inValid = v;
        inSof   = sof;
        inPixel = pix;
        chk("inReady0", rdy0, m_flush == 0);
        chk("inReady1", rdy1, m_flush == 0);
        if (!rdy0) n_busy++;
        model_edge();
        @(posedge clk);
        #1;
        if (val0) win_cnt++;
        chk("outValid0", val0, m_v);
        chk("outValid1", val1, m_v);
        chk("outEof0", eof0, m_eof);
        chk("outEof1", eof1, m_eof);
        chk("outX0", x0, m_x);
        chk("outX1", x1, m_x);
        chk("outY0", y0, m_y);
        chk("outY1", y1, m_y);
        chk("winOut0", win0, m_w0);
        chk("winOut1", win1, m_w1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input int npix, input bit seq, input int max_gap);
        for (int i = 0; i < npix; i++) begin
            repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'($urandom_range(0, 1)), PW'($urandom));
            cycle(1'b1, i == 0, seq ? PW'(i + 1) : PW'($urandom));
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_flush = 0;
        m_n     = 0;
        m_v     = 1'b0;
        m_eof   = 1'b0;
        m_x     = '0;
        m_y     = '0;
        m_w0    = '0;
        m_w1    = '0;
    endtask

    initial begin
        #1 rstN = 1'b0;
        #1;
        model_reset();
        chk("rst_outValid", val0, 1'b0);
        chk("rst_outEof", eof1, 1'b0);
        chk("rst_outX", x0, '0);
        chk("rst_outY", y1, '0);
        chk("rst_winOut", win0, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Sequential frame, no gaps: checks flush length and window count
        win_cnt = 0;
        n_busy  = 0;
        send_frame(N, 1'b1, 0);
        idle(W + 3);
        chk("winsA", win_cnt, N);
        chk("busyA", n_busy, W + 1);

        // Valid pixels without SOF while idle are discarded
        win_cnt = 0;
        repeat (3) cycle(1'b1, 1'b0, PW'($urandom));
        idle(2);
        chk("winsIdle", win_cnt, 0);

        // Random pixels with random stalls
        win_cnt = 0;
        send_frame(N, 1'b0, 2);
        idle(W + 3);
        chk("winsB", win_cnt, N);

        // Abort after 7 pixels, then a complete new frame
        win_cnt = 0;
        send_frame(7, 1'b0, 1);
        send_frame(N, 1'b0, 2);
        idle(W + 3);
        chk("winsAbort", win_cnt, 2 + N);

        // Reset during flush: no further windows, outputs cleared
        win_cnt = 0;
        send_frame(N, 1'b0, 1);
        idle(2);
        rstN = 1'b0;
        #1;
        model_reset();
        chk("rstFlush_outValid0", val0, 1'b0);
        chk("rstFlush_outValid1", val1, 1'b0);
        chk("rstFlush_winOut1", win1, '0);
        @(posedge clk);
        #1;
        chk("rstFlush_ready", rdy0, 1'b1);
        rstN = 1'b1;
        idle(6);
        chk("winsRst", win_cnt, N - W - 1 + 2);

        // Frame after reset processes normally
        win_cnt = 0;
        send_frame(N, 1'b0, 2);
        idle(W + 3);
        chk("winsF", win_cnt, N);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
